rope_rider: RTL and testbench

ROPE_RIDER -- requirements
Module: rope_rider

---
 rtl/rope_rider.sv | 137 +++++++++++++
 tb/tb_rope_rider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rope_rider.sv
// Rope grab/ride/release controller: latches the player onto a moving rope, follows it, and releases on a jump edge.
// Optional ride timeout is enabled by defining ROPE_RIDE_TIMEOUT_EN.
module rope_rider #(
  parameter int GRAB_Y_OFFSET   = 8,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int MAX_RIDE_FRAMES = 120
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collisionRope,
  input  logic               jumpKey,
  input  logic signed [10:0] ropeTopLeftX,
  input  logic signed [10:0] ropeTopLeftY,
  input  logic signed [10:0] ropeWidthX,
  input  logic signed [10:0] playerX,
  output logic               riding,
  output logic signed [10:0] riderX,
  output logic signed [10:0] riderY,
  output logic               releasePulse
);

  typedef enum logic [1:0] {IDLE, RIDE, COOLDOWN} state_t;

  state_t      state;
  logic        hit_flag;
  logic        jump_prev;
  logic [10:0] offset;
  logic [7:0]  cool_count;

  logic               jump_edge;
  logic               grab;
  logic               ride_done;
  logic               release_now;
  logic signed [11:0] diff;
  logic signed [11:0] width_m1;
  logic [10:0]        entry_offset;
  logic [10:0]        reclamp_offset;

  assign jump_edge = jumpKey & ~jump_prev;
  assign grab      = startOfFrame & (hit_flag | collisionRope);

  // Clamp math uses 12 bits so the player/rope distance cannot wrap before clamping.
  assign diff     = {playerX[10], playerX} - {ropeTopLeftX[10], ropeTopLeftX};
  assign width_m1 = {ropeWidthX[10], ropeWidthX} - 12'sd1;

  always_comb begin
    entry_offset   = 11'd0;
    reclamp_offset = 11'd0;
    if (ropeWidthX > 11'sd0) begin
      if (diff < 12'sd0)
        entry_offset = 11'd0;
      else if (diff > width_m1)
        entry_offset = width_m1[10:0];
      else
        entry_offset = diff[10:0];
      if ($signed({1'b0, offset}) > width_m1)
        reclamp_offset = width_m1[10:0];
      else
        reclamp_offset = offset;
    end
  end

`ifdef ROPE_RIDE_TIMEOUT_EN
  logic [15:0] ride_count;
  assign ride_done = startOfFrame && ((ride_count + 16'd1) == 16'(MAX_RIDE_FRAMES));
`else
  logic timeout_unused;
  assign timeout_unused = (MAX_RIDE_FRAMES == 0);
  assign ride_done      = 1'b0;
`endif

  // A jump edge and a timeout on the same frame still produce only one release.
  assign release_now = (state == RIDE) && (jump_edge || ride_done);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state        <= IDLE;
      hit_flag     <= 1'b0;
      jump_prev    <= 1'b0;
      offset       <= 11'd0;
      cool_count   <= 8'd0;
      riding       <= 1'b0;
      riderX       <= 11'sd0;
      riderY       <= 11'sd0;
      releasePulse <= 1'b0;
`ifdef ROPE_RIDE_TIMEOUT_EN
      ride_count   <= 16'd0;
`endif
    end else begin
      jump_prev    <= jumpKey;
      releasePulse <= 1'b0;
      case (state)
        IDLE: begin
          hit_flag <= startOfFrame ? 1'b0 : (hit_flag | collisionRope);
          if (grab) begin
            state  <= RIDE;
            offset <= entry_offset;
            riding <= 1'b1;
`ifdef ROPE_RIDE_TIMEOUT_EN
            ride_count <= 16'd0;
`endif
          end
        end
        RIDE: begin
          hit_flag <= startOfFrame ? 1'b0 : (hit_flag | collisionRope);
          riderX   <= ropeTopLeftX + $signed(offset);
          riderY   <= ropeTopLeftY + $signed(11'(GRAB_Y_OFFSET));
          if (release_now) begin
            state        <= COOLDOWN;
            cool_count   <= 8'(COOLDOWN_FRAMES);
            riding       <= 1'b0;
            releasePulse <= 1'b1;
          end else if (startOfFrame) begin
            offset <= reclamp_offset;
`ifdef ROPE_RIDE_TIMEOUT_EN
            ride_count <= ride_count + 16'd1;
`endif
          end
        end
        COOLDOWN: begin
          hit_flag <= 1'b0;
          if (startOfFrame) begin
            if (cool_count <= 8'd1) begin
              state      <= IDLE;
              cool_count <= 8'd0;
            end else begin
              cool_count <= cool_count - 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rope_rider.sv
// Directed self-checking bench for rope_rider: grab, follow, re-clamp, jump release, cooldown, reset abort, long ride.
module tb_rope_rider;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               collisionRope;
  logic               jumpKey;
  logic signed [10:0] ropeTopLeftX;
  logic signed [10:0] ropeTopLeftY;
  logic signed [10:0] ropeWidthX;
  logic signed [10:0] playerX;
  logic               riding;
  logic signed [10:0] riderX;
  logic signed [10:0] riderY;
  logic               releasePulse;

  int checks   = 0;
  int failures = 0;

  rope_rider dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .collisionRope(collisionRope),
    .jumpKey      (jumpKey),
    .ropeTopLeftX (ropeTopLeftX),
    .ropeTopLeftY (ropeTopLeftY),
    .ropeWidthX   (ropeWidthX),
    .playerX      (playerX),
    .riding       (riding),
    .riderX       (riderX),
    .riderY       (riderY),
    .releasePulse (releasePulse)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int rx, input int ry, input int rw, input int px,
                               input logic coll, input logic jump);
    ropeTopLeftX  = 11'(rx);
    ropeTopLeftY  = 11'(ry);
    ropeWidthX    = 11'(rw);
    playerX       = 11'(px);
    collisionRope = coll;
    jumpKey       = jump;
  endtask

  task automatic pulseFrame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  initial begin
    logic exp_ride;
    logic exp_rel;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    applyStimulus(450, 226, 123, 470, 1'b0, 1'b1);
    tick(2);
    checkOutput("reset_riding", riding, 0);
    checkOutput("reset_riderX", riderX, 0);
    checkOutput("reset_riderY", riderY, 0);
    checkOutput("reset_release", releasePulse, 0);
    resetN = 1'b1;
    tick(3);
    checkOutput("idle_no_hit", riding, 0);

    // Mid-frame collision pulse, grab at next frame start; jump is already held.
    collisionRope = 1'b1;
    tick();
    collisionRope = 1'b0;
    tick(2);
    pulseFrame();
    checkOutput("grab_riding", riding, 1);
    tick();
    checkOutput("grab_riderX", riderX, 470);
    checkOutput("grab_riderY", riderY, 234);
    tick(2);
    checkOutput("held_jump_no_release", releasePulse, 0);
    pulseFrame();
    tick();
    checkOutput("ride_same_offset", riderX, 470);
    ropeTopLeftX = 11'sd500;
    tick();
    checkOutput("follow_rope", riderX, 520);

    // Jump low then high: release on this fresh edge only.
    jumpKey = 1'b0;
    tick();
    checkOutput("jump_low_riding", riding, 1);
    jumpKey = 1'b1;
    tick();
    checkOutput("release_pulse", releasePulse, 1);
    checkOutput("release_riding", riding, 0);
    tick();
    checkOutput("release_one_cycle", releasePulse, 0);
    ropeTopLeftX = 11'sd300;
    tick();
    checkOutput("hold_riderX", riderX, 520);

    // Constant collision during cooldown: no grab for 15 frames, grab on the 16th.
    applyStimulus(300, 226, 123, 400, 1'b1, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      pulseFrame();
      tick(2);
      checkOutput($sformatf("cooldown_f%0d", i), riding, 0);
    end
    pulseFrame();
    checkOutput("regrab_after_cooldown", riding, 1);
    collisionRope = 1'b0;
    tick();
    checkOutput("offset100_riderX", riderX, 400);

    // Rope shrinks to 60: rider pulled in to offset 59 at the next frame start.
    ropeWidthX = 11'sd60;
    tick();
    checkOutput("no_reclamp_midframe", riderX, 400);
    pulseFrame();
    tick();
    checkOutput("reclamp_riderX", riderX, 359);

    // Jump edge on a frame start: release wins.
    jumpKey = 1'b0;
    ropeWidthX = 11'sd30;
    tick();
    startOfFrame = 1'b1;
    jumpKey      = 1'b1;
    tick();
    startOfFrame = 1'b0;
    checkOutput("sof_jump_release", releasePulse, 1);
    checkOutput("sof_jump_riding", riding, 0);
    checkOutput("sof_jump_riderX", riderX, 359);

    // Reset in cooldown aborts it; grab is possible at the very next frame.
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    checkOutput("rst_cool_riding", riding, 0);
    checkOutput("rst_cool_riderX", riderX, 0);
    applyStimulus(300, 226, 60, 250, 1'b1, 1'b0);
    tick();
    collisionRope = 1'b0;
    pulseFrame();
    checkOutput("grab_after_rst", riding, 1);
    tick();
    checkOutput("clamp_low_riderX", riderX, 300);
    checkOutput("clamp_low_riderY", riderY, 234);
    ropeTopLeftY = 11'sd1020;
    tick();
    checkOutput("riderY_wrap", riderY, -1020);

    // Reset during ride, with a jump edge present: no release pulse.
    resetN  = 1'b0;
    jumpKey = 1'b1;
    tick();
    resetN = 1'b1;
    checkOutput("rst_ride_riding", riding, 0);
    checkOutput("rst_ride_riderX", riderX, 0);
    checkOutput("rst_ride_riderY", riderY, 0);
    checkOutput("rst_ride_release", releasePulse, 0);

    // Zero-width rope grabs at offset 0, then ride for 200 frames without a jump.
    applyStimulus(300, 226, 0, 500, 1'b1, 1'b0);
    tick();
    collisionRope = 1'b0;
    pulseFrame();
    checkOutput("grab_zero_width", riding, 1);
    ropeWidthX = 11'sd123;
    tick();
    checkOutput("zero_width_riderX", riderX, 300);
    for (int i = 1; i <= 200; i++) begin
      pulseFrame();
`ifdef ROPE_RIDE_TIMEOUT_EN
      exp_ride = (i < 120);
      exp_rel  = (i == 120);
`else
      exp_ride = 1'b1;
      exp_rel  = 1'b0;
`endif
      checkOutput($sformatf("long_release_f%0d", i), releasePulse, exp_rel);
      checkOutput($sformatf("long_riding_f%0d", i), riding, exp_ride);
      tick(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
